// File: rtl/instr_loader.sv
// instr_loader: boot-time byte-stream loader. Assembles big-endian 32-bit words,
// writes them into the CPU instruction memory, then holds and releases CPU reset.
module instr_loader #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS  = 64,
    parameter int unsigned RST_HOLD   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        initialize,
    output logic [31:0] instruction_initialize_data,
    output logic [31:0] instruction_initialize_address,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        FLUSH  = 3'd4,
        HOLD   = 3'd5,
        RUN    = 3'd6,
        ERR    = 3'd7
    } state_t;

    localparam logic [15:0] MAX_W     = 16'(MAX_WORDS);
    localparam logic [7:0]  HOLD_INIT = 8'(RST_HOLD - 1);

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] data_q, data_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] words_q, words_d;
    logic [7:0]  hold_q, hold_d;
    logic        in_ready_q, in_ready_d;
    logic        initialize_q, initialize_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        accept_s;

    // in_ready is a registered state decode, so no path from in_valid to in_ready
    assign accept_s = in_valid && in_ready_q;

    // Next-state and datapath computation
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        data_d     = data_q;
        addr_d     = addr_q;
        words_d    = words_q;
        hold_d     = hold_q;
        case (state_q)
            IDLE, RUN, ERR: begin
                if (start) begin
                    state_d    = HDR_HI;
                    words_d    = 16'd0;
                    data_d     = 32'd0;
                    addr_d     = START_ADDR;
                    byte_cnt_d = 2'd0;
                    asm_d      = 32'd0;
                end else begin
                    state_d = state_q;
                end
            end
            HDR_HI: begin
                if (accept_s) begin
                    count_d = {in_data, count_q[7:0]};
                    state_d = HDR_LO;
                end else begin
                    state_d = HDR_HI;
                end
            end
            HDR_LO: begin
                if (accept_s) begin
                    count_d = {count_q[15:8], in_data};
                    if (count_d == 16'd0) begin
                        state_d = HOLD;
                        hold_d  = HOLD_INIT;
                    end else if (count_d > MAX_W) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = HDR_LO;
                end
            end
            DATA: begin
                if (accept_s) begin
                    asm_d      = {asm_q[23:0], in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Address uses the pre-increment count: word k lands at START_ADDR + 4k
                        data_d  = asm_d;
                        addr_d  = START_ADDR + {14'd0, words_q, 2'b00};
                        words_d = words_q + 16'd1;
                        if (words_d == count_q) begin
                            state_d = FLUSH;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            FLUSH: begin
                state_d = HOLD;
                hold_d  = HOLD_INIT;
            end
            HOLD: begin
                if (hold_q == 8'd0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode of the next state, registered alongside it
    always_comb begin
        in_ready_d   = 1'b0;
        initialize_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;
        cpu_rst_d    = 1'b1;
        case (state_d)
            HDR_HI, HDR_LO, DATA: begin
                in_ready_d   = 1'b1;
                initialize_d = 1'b1;
                busy_d       = 1'b1;
            end
            FLUSH: begin
                initialize_d = 1'b1;
                busy_d       = 1'b1;
            end
            HOLD:    busy_d = 1'b1;
            RUN: begin
                done_d    = 1'b1;
                cpu_rst_d = 1'b0;
            end
            ERR:     error_d = 1'b1;
            default: cpu_rst_d = 1'b1;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            count_q      <= 16'd0;
            byte_cnt_q   <= 2'd0;
            asm_q        <= 32'd0;
            data_q       <= 32'd0;
            addr_q       <= START_ADDR;
            words_q      <= 16'd0;
            hold_q       <= 8'd0;
            in_ready_q   <= 1'b0;
            initialize_q <= 1'b0;
            cpu_rst_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            words_q      <= words_d;
            hold_q       <= hold_d;
            in_ready_q   <= in_ready_d;
            initialize_q <= initialize_d;
            cpu_rst_q    <= cpu_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign in_ready                       = in_ready_q;
    assign initialize                     = initialize_q;
    assign instruction_initialize_data    = data_q;
    assign instruction_initialize_address = addr_q;
    assign cpu_rst                        = cpu_rst_q;
    assign busy                           = busy_q;
    assign done                           = done_q;
    assign error                          = error_q;
    assign words_loaded                   = words_q;
endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader: vector table of loads with random payloads and gaps,
// an instruction-memory model, plus hand sequences for reset abort and a relocated load.
module tb_instr_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready, initialize, cpu_rst, busy, done, error;
    logic [31:0] init_data, init_addr;
    logic [15:0] words_loaded;

    logic        start2 = 1'b0;
    logic [7:0]  in_data2 = 8'd0;
    logic        in_valid2 = 1'b0;
    logic        in_ready2, initialize2, cpu_rst2, busy2, done2, error2;
    logic [31:0] init_data2, init_addr2;
    logic [15:0] words_loaded2;

    localparam int RST_HOLD = 4;

    int total = 0;
    int bad = 0;

    logic [31:0] pay [64];
    logic [31:0] mem [64];
    logic [7:0]  strm_q [$];
    logic        mon_en = 1'b0;
    int          init_cyc, hold_cyc, viol;

    instr_loader #(.START_ADDR(32'h0), .MAX_WORDS(64), .RST_HOLD(RST_HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .initialize(initialize),
        .instruction_initialize_data(init_data), .instruction_initialize_address(init_addr),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
    );

    instr_loader #(.START_ADDR(32'h40), .MAX_WORDS(64), .RST_HOLD(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .initialize(initialize2),
        .instruction_initialize_data(init_data2), .instruction_initialize_address(init_addr2),
        .cpu_rst(cpu_rst2), .busy(busy2), .done(done2), .error(error2), .words_loaded(words_loaded2)
    );

    always #5 clk = ~clk;

    // Instruction-memory model and per-load observers
    always @(negedge clk) begin : mon
        int w;
        if (mon_en) begin
            w = int'(words_loaded);
            if (initialize) begin
                init_cyc++;
                mem[init_addr[7:2]] = init_data;
            end
            if (busy && !initialize) hold_cyc++;
            if (busy) begin
                if (w == 0) begin
                    if (init_addr !== 32'h0 || init_data !== 32'h0) viol++;
                end else if (w > 64) begin
                    viol++;
                end else if (init_addr !== 32'(4 * (w - 1)) || init_data !== pay[w-1]) begin
                    viol++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_init"}, 32'(initialize), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
        chk({tag, "_data"}, init_data, 32'd0);
        chk({tag, "_addr"}, init_addr, 32'd0);
        chk({tag, "_cpurst"}, 32'(cpu_rst), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(error), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int gap_pct);
        int cyc;
        logic acc;
        cyc = 0;
        while (strm_q.size() > 0 && cyc < 3000) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? strm_q[0] : 8'($urandom);
            acc      = in_valid && in_ready;
            @(negedge clk);
            if (acc) void'(strm_q.pop_front());
            cyc++;
        end
        in_valid = 1'b0;
        chk("feed_budget", 32'(cyc < 3000), 32'd1);
    endtask

    // One complete load on dut; payload is taken from pay[]
    task automatic run_load(input logic [15:0] cnt, input int gap_pct,
                            input logic exp_err, input int exp_words);
        int nw, cyc, exp_init;
        nw = exp_err ? 0 : int'(cnt);
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_BEEF;
        init_cyc = 0; hold_cyc = 0; viol = 0;
        strm_q.delete();
        strm_q.push_back(cnt[15:8]);
        strm_q.push_back(cnt[7:0]);
        for (int i = 0; i < nw; i++) begin
            strm_q.push_back(pay[i][31:24]);
            strm_q.push_back(pay[i][23:16]);
            strm_q.push_back(pay[i][15:8]);
            strm_q.push_back(pay[i][7:0]);
        end
        mon_en = 1'b1;
        pulse_start();
        chk("arm_cpurst", 32'(cpu_rst), 32'd1);
        chk("arm_done", 32'(done), 32'd0);
        chk("arm_err", 32'(error), 32'd0);
        chk("arm_words", 32'(words_loaded), 32'd0);
        chk("arm_rdy", 32'(in_ready), 32'd1);
        feed(gap_pct);
        cyc = 0;
        while (!(done || error) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        mon_en = 1'b0;
        chk("finish_budget", 32'(cyc < 500), 32'd1);
        chk("words_loaded", 32'(words_loaded), 32'(exp_words));
        chk("midword_stable", 32'(viol), 32'd0);
        exp_init = exp_err ? 2 : (2 + 4 * nw + ((nw > 0) ? 1 : 0));
        if (gap_pct == 0) chk("init_cycles", 32'(init_cyc), 32'(exp_init));
        if (exp_err) begin
            chk("err_flag", 32'(error), 32'd1);
            chk("err_init", 32'(initialize), 32'd0);
            chk("err_cpurst", 32'(cpu_rst), 32'd1);
            in_valid = 1'b1;
            in_data  = 8'hA5;
            repeat (3) begin
                @(negedge clk);
                chk("err_rdy", 32'(in_ready), 32'd0);
            end
            in_valid = 1'b0;
            chk("err_hold_words", 32'(words_loaded), 32'd0);
        end else begin
            chk("done_flag", 32'(done), 32'd1);
            chk("run_cpurst", 32'(cpu_rst), 32'd0);
            chk("run_busy", 32'(busy), 32'd0);
            chk("hold_cycles", 32'(hold_cyc), 32'(RST_HOLD));
            for (int i = 0; i < nw; i++) chk($sformatf("mem[%0d]", i), mem[i], pay[i]);
        end
    endtask

    typedef struct {
        logic [15:0] cnt;
        int          gap_pct;
        logic        fixed_prog;
        logic        exp_err;
        int          exp_words;
    } vec_t;

    initial begin
        vec_t vecs [10];
        logic [7:0] b2 [6];
        vecs[0] = '{16'd3,      0,  1'b1, 1'b0, 3};
        vecs[1] = '{16'd0,      0,  1'b0, 1'b0, 0};
        vecs[2] = '{16'h0041,   0,  1'b0, 1'b1, 0};
        vecs[3] = '{16'd1,      0,  1'b0, 1'b0, 1};
        vecs[4] = '{16'd64,     0,  1'b0, 1'b0, 64};
        vecs[5] = '{16'd2,      0,  1'b0, 1'b0, 2};
        vecs[6] = '{16'd2,      50, 1'b0, 1'b0, 2};
        vecs[7] = '{16'h0100,   0,  1'b0, 1'b1, 0};
        vecs[8] = '{16'd5,      30, 1'b0, 1'b0, 5};
        vecs[9] = '{16'd7,      60, 1'b0, 1'b0, 7};

        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        chk("reset_addr2", init_addr2, 32'h40);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_cpurst", 32'(cpu_rst), 32'd1);

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].fixed_prog) begin
                pay[0] = 32'h2008_0005;
                pay[1] = 32'h2009_0007;
                pay[2] = 32'h0109_5020;
            end else begin
                for (int i = 0; i < 64; i++) pay[i] = $urandom;
            end
            run_load(vecs[v].cnt, vecs[v].gap_pct, vecs[v].exp_err, vecs[v].exp_words);
        end

        // Reset part-way through a 3-word load, then reload cleanly
        for (int i = 0; i < 64; i++) pay[i] = $urandom;
        strm_q.delete();
        strm_q.push_back(8'h00);
        strm_q.push_back(8'h03);
        for (int i = 0; i < 6; i++) strm_q.push_back(8'(i + 1));
        pulse_start();
        feed(0);
        chk("abort_progress", 32'(words_loaded), 32'd1);
        rst = 1'b0;
        #1;
        chk_reset("abort_async");
        @(negedge clk);
        chk_reset("abort_next");
        rst = 1'b1;
        @(negedge clk);
        run_load(16'd3, 0, 1'b0, 3);

        // Relocated image on the second instance
        b2[0] = 8'h00; b2[1] = 8'h01; b2[2] = 8'hDE; b2[3] = 8'hAD; b2[4] = 8'hC0; b2[5] = 8'hDE;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("reloc_arm_addr", init_addr2, 32'h40);
        chk("reloc_arm_data", init_data2, 32'h0);
        for (int i = 0; i < 6; i++) begin
            in_data2  = b2[i];
            in_valid2 = 1'b1;
            @(negedge clk);
        end
        in_valid2 = 1'b0;
        chk("reloc_addr", init_addr2, 32'h40);
        chk("reloc_data", init_data2, 32'hDEAD_C0DE);
        chk("reloc_flush_init", 32'(initialize2), 32'd1);
        begin
            int cyc;
            cyc = 0;
            while (!done2 && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            chk("reloc_budget", 32'(cyc < 50), 32'd1);
        end
        chk("reloc_words", 32'(words_loaded2), 32'd1);
        chk("reloc_cpurst", 32'(cpu_rst2), 32'd0);
        chk("reloc_err", 32'(error2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
